// File: rtl/lcd_pkg.sv
// Shared definitions for the SC1602 refresh scheduler: FSM states, LCD command bytes,
// DDRAM line addresses and small lookup helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
        StClrWait,
        StIdle,
        StSetAddr,
        StSendChar
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET   = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY      = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_LINE0_ADDR = 8'h80;
    localparam logic [7:0] LCD_LINE1_ADDR = 8'hC0;

    localparam int unsigned NUM_CELLS = 32;

    // Init command list, issued in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        unique case (idx)
            2'd0: cmd = LCD_FUNC_SET;
            2'd1: cmd = LCD_DISP_ON;
            2'd2: cmd = LCD_ENTRY;
            2'd3: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] line_addr(input logic line);
        return line ? LCD_LINE1_ADDR : LCD_LINE0_ADDR;
    endfunction

endpackage

// File: rtl/lcd_text_buffer.sv
// 32x8 shadow text buffer with per-line dirty flags. Synchronous write/clear,
// asynchronous read.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr_req,
    input  logic [1:0] dirty_clr,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [1:0] dirty
);

    logic [7:0] cells_q [NUM_CELLS];
    logic [1:0] dirty_q;
    logic [1:0] dirty_d;

    // Cell storage: clear fills everything, a same-cycle write then overrides its cell.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                cells_q[i] <= FILL_CHAR;
            end
        end else begin
            if (clr_req) begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    cells_q[i] <= FILL_CHAR;
                end
            end
            if (wr_en) begin
                cells_q[wr_addr] <= wr_data;
            end
        end
    end

    // Dirty next-state: setting (write or clear) wins over the scheduler's pick-clear.
    always_comb begin
        dirty_d = dirty_q & ~dirty_clr;
        if (clr_req) begin
            dirty_d = 2'b11;
        end
        if (wr_en) begin
            dirty_d[wr_addr[4]] = 1'b1;
        end
    end

    // Dirty flag register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dirty_q <= 2'b11;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign rd_data = cells_q[rd_addr];
    assign dirty   = dirty_q;

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// SC1602 refresh scheduler: power-up wait, init command list, then streams dirty
// lines from the shadow buffer to the LCD bus driver over a valid/ready byte interface.
module lcd_refresh_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = 1080000,  // must be >= 1
    parameter int unsigned CLEAR_CYC   = 41040,    // must be >= 1
    parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr_req,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned MAX_CYC = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYC - 1);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_sat;
    logic [1:0]       init_idx_q;
    logic             line_q;
    logic [3:0]       col_q;

    logic       hs;
    logic       pick;
    logic       pick_line;
    logic [1:0] dirty;
    logic [1:0] dirty_clr;
    logic [3:0] rd_col;
    logic [7:0] rd_data;

    lcd_text_buffer #(
        .FILL_CHAR (FILL_CHAR)
    ) u_buf (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .dirty_clr (dirty_clr),
        .rd_addr   ({line_q, rd_col}),
        .rd_data   (rd_data),
        .dirty     (dirty)
    );

    assign hs   = cmd_valid & cmd_ready;
    assign busy = (state_q != StIdle);

    // Line pick (line 0 first) and the cell to present on the next handshake.
    always_comb begin
        pick      = (state_q == StIdle) && (dirty != 2'b00);
        pick_line = ~dirty[0];
        dirty_clr = 2'b00;
        if (pick) begin
            dirty_clr[pick_line] = 1'b1;
        end
        // Cell is fetched at presentation time so late host writes are picked up.
        rd_col  = (state_q == StSendChar) ? col_q + 4'd1 : 4'd0;
        cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StPwrWait;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            line_q     <= 1'b0;
            col_q      <= 4'd0;
            cmd_valid  <= 1'b0;
            cmd_rs     <= 1'b0;
            cmd_byte   <= 8'h00;
            init_done  <= 1'b0;
        end else begin
            unique case (state_q)
                StPwrWait: begin
                    if (cnt_q >= PWR_LAST) begin
                        cnt_q      <= '0;
                        init_idx_q <= 2'd0;
                        cmd_valid  <= 1'b1;
                        cmd_rs     <= 1'b0;
                        cmd_byte   <= init_cmd(2'd0);
                        state_q    <= StInit;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                StInit: begin
                    if (hs) begin
                        if (init_idx_q == 2'd3) begin
                            cmd_valid <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= StClrWait;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                            cmd_byte   <= init_cmd(init_idx_q + 2'd1);
                        end
                    end
                end
                StClrWait: begin
                    if (cnt_q >= CLR_LAST) begin
                        cnt_q     <= '0;
                        init_done <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                StIdle: begin
                    if (pick) begin
                        line_q    <= pick_line;
                        col_q     <= 4'd0;
                        cmd_valid <= 1'b1;
                        cmd_rs    <= 1'b0;
                        cmd_byte  <= line_addr(pick_line);
                        state_q   <= StSetAddr;
                    end
                end
                StSetAddr: begin
                    if (hs) begin
                        col_q    <= 4'd0;
                        cmd_rs   <= 1'b1;
                        cmd_byte <= rd_data;
                        state_q  <= StSendChar;
                    end
                end
                StSendChar: begin
                    if (hs) begin
                        if (col_q == 4'hF) begin
                            col_q     <= 4'd0;
                            cmd_valid <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            col_q    <= col_q + 4'd1;
                            cmd_byte <= rd_data;
                        end
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    state_q   <= StPwrWait;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed scoreboard bench for lcd_refresh_scheduler.
module tb_lcd_refresh_scheduler;

    localparam int unsigned POWERUP_CYC = 20;
    localparam int unsigned CLEAR_CYC   = 10;

    logic       sys_clk   = 1'b0;
    logic       sys_rst   = 1'b1;
    logic       wr_en     = 1'b0;
    logic [4:0] wr_addr   = 5'd0;
    logic [7:0] wr_data   = 8'd0;
    logic       clr_req   = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_byte;
    logic       init_done;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic [7:0] model [32];

    bit bp_mode   = 1'b0;
    bit force_low = 1'b0;
    int hold_cnt  = 0;

    logic       pv   = 1'b0;
    logic       pr   = 1'b0;
    logic       prst = 1'b1;
    logic       prs  = 1'b0;
    logic [7:0] pb   = 8'd0;

    always #5 sys_clk = ~sys_clk;

    lcd_refresh_scheduler #(
        .POWERUP_CYC (POWERUP_CYC),
        .CLEAR_CYC   (CLEAR_CYC),
        .FILL_CHAR   (8'h20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_byte  (cmd_byte),
        .init_done (init_done),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver-side ready: always high, or 5 low cycles per presented byte, or forced low.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (force_low) begin
                cmd_ready = 1'b0;
            end else if (!bp_mode) begin
                cmd_ready = 1'b1;
            end else if (cmd_valid) begin
                if (hold_cnt >= 5) begin
                    cmd_ready = 1'b1;
                    hold_cnt  = 0;
                end else begin
                    cmd_ready = 1'b0;
                    hold_cnt++;
                end
            end else begin
                cmd_ready = 1'b0;
                hold_cnt  = 0;
            end
        end
    end

    // Monitor: stability under backpressure and scoreboard pop on every handshake.
    always @(negedge sys_clk) begin
        if (!sys_rst && !prst && pv && !pr) begin
            chk("hold_valid", 16'(cmd_valid), 16'd1);
            chk("hold_byte", 16'({cmd_rs, cmd_byte}), 16'({prs, pb}));
        end
        if (!sys_rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 16'({cmd_rs, cmd_byte}), 16'hFFFF);
            end else begin
                exp_item = exp_q.pop_front();
                chk("cmd_byte", 16'({cmd_rs, cmd_byte}), 16'(exp_item));
            end
            acc_cnt++;
        end
        pv   = cmd_valid;
        pr   = cmd_ready;
        prst = sys_rst;
        prs  = cmd_rs;
        pb   = cmd_byte;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_fill();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h28});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_line(input logic line, input int ncols);
        exp_q.push_back({1'b0, line ? 8'hC0 : 8'h80});
        for (int c = 0; c < ncols; c++) exp_q.push_back({1'b1, model[{line, 4'(c)}]});
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d, input logic clr);
        @(posedge sys_clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        clr_req = clr;
        @(posedge sys_clk);
        #1;
        wr_en   = 1'b0;
        clr_req = 1'b0;
        if (clr) model_fill();
        model[a] = d;
    endtask

    task automatic wait_acc(input int target, input string tag);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk(tag, 16'(acc_cnt >= target), 16'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk(tag, 16'(exp_q.size()), 16'd0);
        repeat (4) @(posedge sys_clk);
        #1;
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_valid"}, 16'(cmd_valid), 16'd0);
    endtask

    initial begin
        int n;
        int base;
        model_fill();

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_valid", 16'(cmd_valid), 16'd0);
        chk("rst_rs", 16'(cmd_rs), 16'd0);
        chk("rst_byte", 16'(cmd_byte), 16'd0);
        chk("rst_init_done", 16'(init_done), 16'd0);
        chk("rst_busy", 16'(busy), 16'd1);

        // Init list and first full refresh
        push_init();
        push_line(1'b0, 16);
        push_line(1'b1, 16);
        sys_rst = 1'b0;
        n = 0;
        while (!cmd_valid && n < 200) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk("powerup_cycles", 16'(n), 16'(POWERUP_CYC));
        wait_acc(4, "init_list_accepted");
        chk("init_done_after_clear_cmd", 16'(init_done), 16'd0);
        n = 0;
        while (!init_done && n < 200) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk("clear_wait_cycles", 16'(n), 16'(CLEAR_CYC));
        wait_drain("first_refresh");
        chk("init_done_held", 16'(init_done), 16'd1);

        // Backpressure plus single write at 5'h03
        bp_mode = 1'b1;
        host_write(5'h03, 8'h48, 1'b0);
        push_line(1'b0, 16);
        wait_drain("bp_write_h");
        bp_mode = 1'b0;

        // Writes to line 1 and to line 0 while line 0 is being sent
        base = acc_cnt;
        host_write(5'h01, 8'h31, 1'b0);
        push_line(1'b0, 16);
        wait_acc(base + 5, "mid_line0_col3");
        host_write(5'h12, 8'h42, 1'b0);
        wait_acc(base + 12, "mid_line0_col10");
        host_write(5'h07, 8'h37, 1'b0);
        push_line(1'b0, 16);
        push_line(1'b1, 16);
        wait_drain("mid_writes");

        // Clear and write in the same cycle
        host_write(5'h00, 8'h41, 1'b1);
        push_line(1'b0, 16);
        push_line(1'b1, 16);
        wait_drain("clr_with_write");

        // Reset while column 7 of line 0 is presented
        base = acc_cnt;
        host_write(5'h05, 8'h35, 1'b0);
        push_line(1'b0, 7);
        wait_acc(base + 8, "reach_col7");
        sys_rst   = 1'b1;
        force_low = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("midrst_valid", 16'(cmd_valid), 16'd0);
        chk("midrst_init_done", 16'(init_done), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd1);
        chk("midrst_queue", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        model_fill();
        push_init();
        push_line(1'b0, 16);
        push_line(1'b1, 16);
        sys_rst   = 1'b0;
        force_low = 1'b0;
        wait_drain("restart_after_reset");
        chk("restart_init_done", 16'(init_done), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
